// File: rtl/uart_tx_byte_fifo_if.sv
// Signal bundle between byte producers, the transmit FIFO and the UART transmitter.
// The slave modport is the FIFO's view; the master modport is the surrounding environment.
interface uart_tx_byte_fifo_if #(
    parameter int DBIT       = 8,
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [DBIT-1:0]       wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  tx_start;
    logic [DBIT-1:0]       tx_data;
    logic                  tx_done_tick;
    logic                  busy;

    modport master (
        output wr_en,
        output wr_data,
        output tx_done_tick,
        input  full,
        input  empty,
        input  count,
        input  overflow,
        input  tx_start,
        input  tx_data,
        input  busy
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  tx_done_tick,
        output full,
        output empty,
        output count,
        output overflow,
        output tx_start,
        output tx_data,
        output busy
    );
endinterface

// File: rtl/uart_tx_byte_fifo.sv
// Byte FIFO plus issue sequencer feeding a UART transmitter one byte per frame.
// A byte is handed over with a single-cycle tx_start; the next waits for tx_done_tick.
module uart_tx_byte_fifo #(
    parameter int DBIT       = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_tx_byte_fifo_if.slave bus
);
    localparam int                   DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [DBIT-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  full_q;
    logic                  empty_q;
    logic                  overflow_q;
    logic [DBIT-1:0]       tx_data_q;
    logic                  push;
    logic                  pop;
    logic                  tx_start_c;
    logic                  busy_c;

    // full is the registered flag, so a same-cycle pop never frees room for a write
    assign push = bus.wr_en && !full_q;
    assign pop  = (state == ST_IDLE) && !empty_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + CNT_ONE;
            2'b01:   count_next = count_q - CNT_ONE;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_next;
            full_q     <= (count_next == FULL_COUNT);
            empty_q    <= (count_next == '0);
            overflow_q <= bus.wr_en && full_q;
        end
    end

    // tx_data holds the last issued byte until the next pop replaces it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data_q <= '0;
        end else if (pop) begin
            tx_data_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!empty_q) state_next = ST_START;
            ST_START: state_next = ST_WAIT;
            ST_WAIT:  if (bus.tx_done_tick) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_start_c = (state == ST_START);
        busy_c     = (state != ST_IDLE) || !empty_q;
    end

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.tx_start = tx_start_c;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_c;
endmodule
